// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: registered, handshaked memory/IO bus controller.
// Each CPU access is latched in IDLE and gets region strobes for a configurable number of wait
// states. Registered read data then returns with a one-cycle ready pulse.
// Optional feature: define MIO_BUS_ERR_EN to flag unmapped accesses on bus_err.
module mio_bus_ctrl #(
  parameter int unsigned RAM_AW   = 13,
  parameter int unsigned VRAM_AW  = 14,
  parameter int unsigned VRAM_DW  = 11,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  // CPU side
  input  logic               req,
  input  logic               mem_w,
  input  logic [31:0]        addr_bus,
  input  logic [31:0]        Cpu_data2bus,
  output logic [31:0]        Cpu_data4bus,
  output logic               ready,
  output logic               bus_err,
  // data RAM
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [31:0]        ram_data_in,
  input  logic [31:0]        ram_data_out,
  output logic               data_ram_we,
  output logic               Byte_Sel,
  // VRAM write port
  output logic               Vram_W_En,
  output logic [VRAM_AW-1:0] Vram_W_Addr_x_y,
  output logic [VRAM_DW-1:0] Vram_W_Data,
  // PS/2 receiver
  input  logic               ps2_ready,
  input  logic [7:0]         key_scan,
  output logic               ps2_rd,
  // GPIO and counter
  output logic               GPIOe0000000_we,
  output logic               GPIOf0000000_we,
  output logic               counter_we,
  output logic [31:0]        Peripheral_in,
  input  logic [31:0]        counter_out,
  input  logic               counter0_out,
  input  logic               counter1_out,
  input  logic               counter2_out,
  input  logic [7:0]         led_out,
  input  logic [4:0]         BTN,
  input  logic [7:0]         SW
);

  // Latch just enough address bits to serve both RAM and VRAM addressing.
  localparam int unsigned AddrW = (RAM_AW + 2 > VRAM_AW) ? RAM_AW + 2 : VRAM_AW;

  localparam logic [3:0] RamWait = 4'(RAM_WAIT);
  localparam logic [3:0] IoWait  = 4'(IO_WAIT);

  // One-hot region bits; the all-zero vector means an unmapped (NONE) access.
  localparam int unsigned RgRam  = 0;
  localparam int unsigned RgVram = 1;
  localparam int unsigned RgPs2  = 2;
  localparam int unsigned RgGpe  = 3;
  localparam int unsigned RgGpf  = 4;
  localparam int unsigned RgCnt  = 5;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [5:0]       region_q, region_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [5:0]       region_dec;
  logic [31:0]      rd_mux;

  // Address decode of the live CPU address, used only at capture time.
  always_comb begin
    region_dec = '0;
    if (addr_bus[31:16] == 16'h0000) begin
      region_dec[RgRam] = 1'b1;
    end else if (addr_bus[31:16] == 16'h000c) begin
      region_dec[RgVram] = 1'b1;
    end else if (addr_bus[31:12] == 20'hffffd) begin
      region_dec[RgPs2] = 1'b1;
    end else if (addr_bus[31:8] == 24'hfffffe) begin
      region_dec[RgGpe] = 1'b1;
    end else if (addr_bus[31:8] == 24'hffffff) begin
      if (addr_bus[2]) begin
        region_dec[RgCnt] = 1'b1;
      end else begin
        region_dec[RgGpf] = 1'b1;
      end
    end
  end

  // Read-data source for the latched region.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      region_q[RgRam]: rd_mux = ram_data_out;
      region_q[RgPs2]: rd_mux = {23'b0, ps2_ready, key_scan};
      region_q[RgGpe]: rd_mux = counter_out;
      region_q[RgCnt]: rd_mux = counter_out;
      region_q[RgGpf]: rd_mux = {counter0_out, counter1_out, counter2_out, 8'h00,
                                 led_out, BTN, SW};
      default:         rd_mux = '0;
    endcase
  end

  // State and latch registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      region_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      region_q <= region_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state: capture in IDLE, count wait states in ACCESS, one DONE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    region_d = region_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d   = addr_bus[AddrW-1:0];
          wdata_d  = Cpu_data2bus;
          we_d     = mem_w;
          region_d = region_dec;
          cnt_d    = region_dec[RgRam] ? RamWait : IoWait;
          first_d  = 1'b1;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        first_d = 1'b0;
        if (cnt_q == 4'd0) begin
          rdata_d = we_q ? 32'h0 : rd_mux;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Region outputs: only the latched region is driven, and only during ACCESS.
  always_comb begin
    ram_addr        = '0;
    ram_data_in     = '0;
    data_ram_we     = 1'b0;
    Byte_Sel        = 1'b0;
    Vram_W_En       = 1'b0;
    Vram_W_Addr_x_y = '0;
    Vram_W_Data     = '0;
    ps2_rd          = 1'b0;
    GPIOe0000000_we = 1'b0;
    GPIOf0000000_we = 1'b0;
    counter_we      = 1'b0;
    Peripheral_in   = '0;
    if (state_q == StAccess) begin
      if (region_q[RgRam]) begin
        ram_addr    = addr_q[RAM_AW+1:2];
        ram_data_in = wdata_q;
        Byte_Sel    = addr_q[1];
        data_ram_we = first_q & we_q;
      end
      if (region_q[RgVram]) begin
        Vram_W_Addr_x_y = addr_q[VRAM_AW-1:0];
        Vram_W_Data     = wdata_q[VRAM_DW-1:0];
        Vram_W_En       = first_q & we_q;
      end
      // Consume the PS/2 byte in the same cycle its data is captured.
      if (region_q[RgPs2]) begin
        ps2_rd = (cnt_q == 4'd0) & ~we_q;
      end
      if (region_q[RgGpe] | region_q[RgGpf] | region_q[RgCnt]) begin
        Peripheral_in = wdata_q;
      end
      GPIOe0000000_we = region_q[RgGpe] & first_q & we_q;
      GPIOf0000000_we = region_q[RgGpf] & first_q & we_q;
      counter_we      = region_q[RgCnt] & first_q & we_q;
    end
  end

  assign ready        = (state_q == StDone);
  assign Cpu_data4bus = rdata_q;

`ifdef MIO_BUS_ERR_EN
  assign bus_err = (state_q == StDone) & (region_q == 6'b0);
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: randomized self-checking bench for mio_bus_ctrl against a region-level model.
module tb_mio_bus_ctrl;

  localparam int unsigned RamWait = 1;
  localparam int unsigned IoWait  = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] Cpu_data2bus;
  logic [31:0] Cpu_data4bus;
  logic        ready;
  logic        bus_err;
  logic [12:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic        data_ram_we;
  logic        Byte_Sel;
  logic        Vram_W_En;
  logic [13:0] Vram_W_Addr_x_y;
  logic [10:0] Vram_W_Data;
  logic        ps2_ready;
  logic [7:0]  key_scan;
  logic        ps2_rd;
  logic        GPIOe0000000_we;
  logic        GPIOf0000000_we;
  logic        counter_we;
  logic [31:0] Peripheral_in;
  logic [31:0] counter_out;
  logic        counter0_out;
  logic        counter1_out;
  logic        counter2_out;
  logic [7:0]  led_out;
  logic [4:0]  BTN;
  logic [7:0]  SW;

  mio_bus_ctrl #(
    .RAM_AW  (13),
    .VRAM_AW (14),
    .VRAM_DW (11),
    .RAM_WAIT(RamWait),
    .IO_WAIT (IoWait)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .mem_w          (mem_w),
    .addr_bus       (addr_bus),
    .Cpu_data2bus   (Cpu_data2bus),
    .Cpu_data4bus   (Cpu_data4bus),
    .ready          (ready),
    .bus_err        (bus_err),
    .ram_addr       (ram_addr),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out),
    .data_ram_we    (data_ram_we),
    .Byte_Sel       (Byte_Sel),
    .Vram_W_En      (Vram_W_En),
    .Vram_W_Addr_x_y(Vram_W_Addr_x_y),
    .Vram_W_Data    (Vram_W_Data),
    .ps2_ready      (ps2_ready),
    .key_scan       (key_scan),
    .ps2_rd         (ps2_rd),
    .GPIOe0000000_we(GPIOe0000000_we),
    .GPIOf0000000_we(GPIOf0000000_we),
    .counter_we     (counter_we),
    .Peripheral_in  (Peripheral_in),
    .counter_out    (counter_out),
    .counter0_out   (counter0_out),
    .counter1_out   (counter1_out),
    .counter2_out   (counter2_out),
    .led_out        (led_out),
    .BTN            (BTN),
    .SW             (SW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Region model: 0 RAM, 1 VRAM, 2 PS2, 3 GPIOe, 4 GPIOf, 5 counter, 6 NONE.
  function automatic int region_of(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h000c_0000 && a < 32'h000d_0000) return 1;
    if (a >= 32'hffff_d000 && a < 32'hffff_e000) return 2;
    if (a >= 32'hffff_fe00 && a < 32'hffff_ff00) return 3;
    if (a >= 32'hffff_ff00) return a[2] ? 5 : 4;
    return 6;
  endfunction

  function automatic logic [31:0] read_value(input int rg);
    case (rg)
      0:       return ram_data_out;
      2:       return {23'b0, ps2_ready, key_scan};
      3, 5:    return counter_out;
      4:       return {counter0_out, counter1_out, counter2_out, 8'h00, led_out, BTN, SW};
      default: return 32'h0;
    endcase
  endfunction

  // Strobe bit that a write to each region should raise (PS/2 and NONE have none).
  function automatic logic [4:0] strobe_for(input int rg);
    case (rg)
      0:       return 5'b00001;
      1:       return 5'b00010;
      3:       return 5'b00100;
      4:       return 5'b01000;
      5:       return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] strobes();
    return {counter_we, GPIOf0000000_we, GPIOe0000000_we, Vram_W_En, data_ram_we};
  endfunction

  function automatic logic bus_active();
    return |{ram_addr, ram_data_in, data_ram_we, Byte_Sel, Vram_W_En, Vram_W_Addr_x_y,
             Vram_W_Data, ps2_rd, GPIOe0000000_we, GPIOf0000000_we, counter_we, Peripheral_in};
  endfunction

  task automatic randomize_periph();
    ram_data_out = $urandom;
    key_scan     = 8'($urandom);
    ps2_ready    = 1'($urandom);
    counter_out  = $urandom;
    counter0_out = 1'($urandom);
    counter1_out = 1'($urandom);
    counter2_out = 1'($urandom);
    led_out      = 8'($urandom);
    BTN          = 5'($urandom);
    SW           = 8'($urandom);
  endtask

  // One full CPU access, checked cycle by cycle against the region model.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic we);
    int          rg;
    int          w;
    int          n;
    int          n_stb;
    int          n_ps2;
    bit          got;
    logic [31:0] exp_rd;
    logic [4:0]  seen;
    logic [4:0]  exp_mask;
    logic        exp_err;
    rg       = region_of(a);
    w        = (rg == 0) ? RamWait : IoWait;
    exp_mask = we ? strobe_for(rg) : 5'b0;
`ifdef MIO_BUS_ERR_EN
    exp_err  = (rg == 6);
`else
    exp_err  = 1'b0;
`endif
    @(negedge clk);
    addr_bus     = a;
    Cpu_data2bus = wd;
    mem_w        = we;
    req          = 1'b1;
    exp_rd       = we ? 32'h0 : read_value(rg);
    @(negedge clk);
    // The access is latched now; scramble the CPU inputs to prove it.
    req          = 1'b0;
    addr_bus     = $urandom;
    Cpu_data2bus = $urandom;
    mem_w        = 1'($urandom);
    check("ram_addr",    32'(ram_addr),        (rg == 0) ? 32'(a[14:2]) : 32'h0);
    check("ram_data_in", ram_data_in,          (rg == 0) ? wd : 32'h0);
    check("byte_sel",    32'(Byte_Sel),        (rg == 0) ? 32'(a[1]) : 32'h0);
    check("vram_addr",   32'(Vram_W_Addr_x_y), (rg == 1) ? 32'(a[13:0]) : 32'h0);
    check("vram_data",   32'(Vram_W_Data),     (rg == 1) ? 32'(wd[10:0]) : 32'h0);
    check("periph_in",   Peripheral_in,        (rg >= 3 && rg <= 5) ? wd : 32'h0);
    seen  = '0;
    n_stb = 0;
    n_ps2 = 0;
    got   = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      seen  = seen | strobes();
      n_stb = n_stb + $countones(strobes());
      n_ps2 = n_ps2 + int'(ps2_rd);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_latency", 32'(n), 32'(w + 1));
    check("strobe_mask",   32'(seen), 32'(exp_mask));
    check("strobe_count",  32'(n_stb), (exp_mask != 0) ? 32'd1 : 32'd0);
    check("ps2_rd_count",  32'(n_ps2), (rg == 2 && !we) ? 32'd1 : 32'd0);
    if (got) begin
      check("rdata",   Cpu_data4bus, exp_rd);
      check("bus_err", 32'(bus_err), 32'(exp_err));
    end
    @(negedge clk);
    check("ready_width", 32'(ready), 32'h0);
    check("rdata_hold",  Cpu_data4bus, exp_rd);
    check("idle_quiet",  32'(bus_active()), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    int          tries;
    int          ready_seen;
    rst          = 1'b0;
    req          = 1'b0;
    mem_w        = 1'b0;
    addr_bus     = '0;
    Cpu_data2bus = '0;
    randomize_periph();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus_active(), ready, bus_err}), 32'h0);
    check("reset_rdata",   Cpu_data4bus, 32'h0);
    rst = 1'b1;

    // Directed cases from the region table.
    access(32'h0000_0010, 32'hdead_beef, 1'b1);
    ram_data_out = 32'h1234_5678;
    access(32'h0000_0012, 32'h0, 1'b0);
    key_scan  = 8'h1c;
    ps2_ready = 1'b1;
    access(32'hffff_d000, 32'h0, 1'b0);
    access(32'hffff_d004, 32'h55, 1'b1);
    access(32'h1234_5678, 32'h0, 1'b0);
    access(32'hffff_fe00, 32'h0bad_f00d, 1'b1);
    access(32'hffff_ff04, 32'h0000_1234, 1'b1);
    SW           = 8'ha5;
    BTN          = 5'h1f;
    led_out      = 8'h3c;
    counter0_out = 1'b1;
    counter1_out = 1'b0;
    counter2_out = 1'b1;
    access(32'hffff_ff00, 32'h0, 1'b0);

    // Reset during the ACCESS cycle after a VRAM write strobe.
    @(negedge clk);
    addr_bus     = 32'h000c_0305;
    Cpu_data2bus = 32'h0000_07ff;
    mem_w        = 1'b1;
    req          = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("rst_case_strobe", 32'(Vram_W_En), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_case_quiet", 32'({bus_active(), ready, bus_err}), 32'h0);
    check("rst_case_rdata", Cpu_data4bus, 32'h0);
    ready_seen = 0;
    repeat (3) begin
      @(negedge clk);
      ready_seen = ready_seen + int'(ready) + int'(bus_active());
    end
    check("rst_case_no_ready", 32'(ready_seen), 32'h0);
    rst = 1'b1;
    access(32'h000c_0123, 32'h0000_0321, 1'b1);

    // Randomized accesses spread over all regions.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h000c, 16'($urandom)};
        2:       a = {20'hffffd, 12'($urandom)};
        3:       a = {24'hfffffe, 8'($urandom)};
        4, 5:    a = {24'hffffff, 8'($urandom)};
        default: begin
          a     = $urandom;
          tries = 0;
          while (region_of(a) != 6 && tries < 100) begin
            a     = $urandom;
            tries = tries + 1;
          end
        end
      endcase
      randomize_periph();
      access(a, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
